// File: rtl/clint_responder_if.sv
// Data-memory bus between the core and a memory-mapped responder.
// The core drives strobes, address and write data; the responder returns read data and hit.
interface clint_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] data_out;
   logic [31:0] rd_data;
   logic        hit;

   modport master (
      output mem_read, mem_write, data_adr, data_out,
      input  rd_data, hit
   );

   modport slave (
      input  mem_read, mem_write, data_adr, data_out,
      output rd_data, hit
   );
endinterface

// File: rtl/clint_responder.sv
// Core-local interruptor: mtime/mtimecmp/msip registers on the data bus.
// Reads are combinational so they complete inside the core's single-cycle memory stage.
module clint_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic               clk,
   input  logic               rst,
   clint_responder_if.slave   bus,
   output logic               machineTimerInterrupt,
   output logic               machineSoftwareInterrupt
);

   localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

   // Word offsets (byte offset >> 2) inside the 64 KiB window.
   localparam logic [13:0] OFF_MSIP   = 14'h0000;
   localparam logic [13:0] OFF_CMP_LO = 14'h1000;
   localparam logic [13:0] OFF_MT_LO  = 14'h2FFE;
   localparam logic [13:0] OFF_MT_HI  = 14'h2FFF;

   logic [PW-1:0] pcnt_reg, pcnt_next;
   logic          tick;
   logic [63:0]   mtime_reg, mtime_next;
   logic [63:0]   mtimecmp;
   logic          msip_reg, msip_next;
   logic [13:0]   word;
   logic          hit_int;
   logic          wr_en;
   logic [31:0]   rd_mux;
   logic          unused_adr_bits;

   assign word            = bus.data_adr[15:2];
   assign unused_adr_bits = ^bus.data_adr[1:0];
   assign hit_int         = (bus.mem_read | bus.mem_write) &&
                            (bus.data_adr[31:16] == BASE_ADDR[31:16]);
   assign wr_en           = hit_int & bus.mem_write;
   assign bus.hit         = hit_int;

   // Prescaler free-runs regardless of any mtime writes.
   assign tick      = (pcnt_reg == PCNT_LAST);
   assign pcnt_next = tick ? '0 : pcnt_reg + PW'(1);

   always_comb begin
      mtime_next = mtime_reg;
      if (wr_en && word == OFF_MT_LO) begin
         mtime_next[31:0] = bus.data_out;
      end else if (wr_en && word == OFF_MT_HI) begin
         mtime_next[63:32] = bus.data_out;
      end else if (tick) begin
         mtime_next = mtime_reg + 64'd1;
      end
   end

   always_comb begin
      msip_next = msip_reg;
      if (wr_en && word == OFF_MSIP) begin
         msip_next = bus.data_out[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_reg  <= '0;
         mtime_reg <= '0;
         msip_reg  <= 1'b0;
      end else begin
         pcnt_reg  <= pcnt_next;
         mtime_reg <= mtime_next;
         msip_reg  <= msip_next;
      end
   end

   // The two mtimecmp halves are written independently.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cmp
         logic [31:0] half_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               half_reg <= '1;
            end else if (wr_en && word == (OFF_CMP_LO + 14'(gi))) begin
               half_reg <= bus.data_out;
            end
         end
         assign mtimecmp[gi*32 +: 32] = half_reg;
      end
   endgenerate

   always_comb begin
      rd_mux = 32'h0;
      if (hit_int && bus.mem_read) begin
         case (word)
            OFF_MSIP:              rd_mux = {31'h0, msip_reg};
            OFF_CMP_LO:            rd_mux = mtimecmp[31:0];
            OFF_CMP_LO + 14'd1:    rd_mux = mtimecmp[63:32];
            OFF_MT_LO:             rd_mux = mtime_reg[31:0];
            OFF_MT_HI:             rd_mux = mtime_reg[63:32];
            default:               rd_mux = 32'h0;
         endcase
      end
   end

   assign bus.rd_data               = rd_mux;
   assign machineTimerInterrupt     = (mtime_reg >= mtimecmp);
   assign machineSoftwareInterrupt  = msip_reg;

endmodule
